// File: rtl/t_chain_unloader_pkg.sv
// Shared definitions for the parallel-load, serial-drain chain unloader.
// Holds the FSM encoding and the counter-width helper.
package t_chain_unloader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // A one-word chain still needs a 1-bit counter, so never return zero.
  function automatic int cntWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/t_chain_unloader_reg.sv
// One stage of the unload chain: parallel load when i_sel=1, shift when i_sel=0.
// Clearing is done by the parent forcing a load of zeros, so there is no reset port.
module T_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_loadData,
  input  logic [WIDTH-1:0] i_shiftData,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_q <= i_sel ? i_loadData : i_shiftData;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/t_chain_unloader.sv
// Accepts a whole frame of DEPTH words in one cycle and streams it out word by word.
// A new frame may load on the last-word handshake, so frames stream without a bubble.
module t_chain_unloader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DEPTH*DATA_WIDTH-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last
);

  import t_chain_unloader_pkg::*;

  localparam int CW = cntWidth(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_count;
  logic            w_accept;
  logic            w_load;
  logic            w_shift;
  logic            w_lastBeat;
  logic [DATA_WIDTH-1:0] w_stage   [DEPTH];
  logic [DATA_WIDTH-1:0] w_shiftIn [DEPTH];

  assign w_accept   = s_valid && s_ready;
  assign w_load     = !aresetn || w_accept;
  assign w_shift    = aresetn && m_valid && m_ready;
  assign w_lastBeat = m_last && m_ready;

  // Reset is realised as a forced load of zeros into every stage.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == DEPTH - 1) begin : g_tail
        assign w_shiftIn[gi] = '0;
      end else begin : g_body
        assign w_shiftIn[gi] = w_stage[gi+1];
      end

      T_reg #(.WIDTH(DATA_WIDTH)) u_reg (
        .clk         (clk),
        .i_en        (w_load || w_shift),
        .i_sel       (w_load),
        .i_loadData  (aresetn ? s_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0),
        .i_shiftData (w_shiftIn[gi]),
        .o_q         (w_stage[gi])
      );
    end
  endgenerate

  // The counter wraps to 0 on the last beat so it never exceeds DEPTH-1.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= '0;
    end else if (w_shift) begin
      r_count <= w_lastBeat ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (s_valid) w_nextState = DRAIN;
      DRAIN:   if (w_lastBeat && !s_valid) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    m_valid = (r_state == DRAIN);
    m_last  = m_valid && (r_count == LAST_IDX);
    s_ready = (r_state == IDLE) || (m_last && m_ready);
    m_data  = w_stage[0];
  end

endmodule

// File: tb/tb_t_chain_unloader.sv
// Directed bench for t_chain_unloader: an 8x16 instance for streaming, stall, overlap
// and reset cases, plus a 1x8 instance for the single-word frame corner.
module tb_t_chain_unloader;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         sValid;
  logic         sReady;
  logic [127:0] sData;
  logic         mValid;
  logic         mReady;
  logic [15:0]  mData;
  logic         mLast;

  logic         s1Valid;
  logic         s1Ready;
  logic [7:0]   s1Data;
  logic         m1Valid;
  logic         m1Ready;
  logic [7:0]   m1Data;
  logic         m1Last;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  t_chain_unloader #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_valid(sValid), .s_ready(sReady), .s_data(sData),
    .m_valid(mValid), .m_ready(mReady), .m_data(mData), .m_last(mLast)
  );

  t_chain_unloader #(.DATA_WIDTH(8), .DEPTH(1)) dutOne (
    .clk(clk), .aresetn(aresetn),
    .s_valid(s1Valid), .s_ready(s1Ready), .s_data(s1Data),
    .m_valid(m1Valid), .m_ready(m1Ready), .m_data(m1Data), .m_last(m1Last)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] makeFrame(input logic [15:0] base);
    logic [127:0] f;
    for (int i = 0; i < 8; i++) f[i*16 +: 16] = base + 16'(i);
    return f;
  endfunction

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    logic mr;

    aresetn = 1'b0; sValid = 1'b0; sData = '0; mReady = 1'b0;
    s1Valid = 1'b0; s1Data = '0; m1Ready = 1'b0;
    applyStimulus();
    applyStimulus();
    aresetn = 1'b1;
    checkOutput("rst_sready", sReady, 1);
    checkOutput("rst_mvalid", mValid, 0);
    checkOutput("rst_mlast",  mLast,  0);
    checkOutput("rst_mdata",  mData,  0);

    // Straight drain with the consumer always ready.
    sValid = 1'b1; sData = makeFrame(16'h0001); mReady = 1'b1;
    applyStimulus();
    sValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t1_valid", mValid, 1);
      checkOutput("t1_data",  mData,  32'(i + 1));
      checkOutput("t1_last",  mLast,  (i == 7) ? 1 : 0);
      applyStimulus();
    end
    checkOutput("t1_idle_valid",  mValid, 0);
    checkOutput("t1_idle_sready", sReady, 1);

    // Consumer alternates ready/not-ready; data must hold while stalled.
    sValid = 1'b1; sData = makeFrame(16'h0001);
    applyStimulus();
    sValid = 1'b0;
    idx = 0; mr = 1'b1;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      mReady = mr;
      checkOutput("t2_valid", mValid, 1);
      checkOutput("t2_data",  mData,  32'(idx + 1));
      checkOutput("t2_last",  mLast,  (idx == 7) ? 1 : 0);
      applyStimulus();
      if (mr) idx++;
      mr = !mr;
    end
    checkOutput("t2_handshakes", idx, 8);
    checkOutput("t2_idle_valid", mValid, 0);
    mReady = 1'b1;

    // Back-to-back frames A then B with no bubble between them.
    sValid = 1'b1; sData = makeFrame(16'h0A00);
    applyStimulus();
    sData = makeFrame(16'h0B00);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t3_valid", mValid, 1);
      checkOutput("t3_data",  mData,  (i < 8) ? 32'(16'h0A00 + i) : 32'(16'h0B00 + i - 8));
      checkOutput("t3_last",  mLast,  (i == 7 || i == 15) ? 1 : 0);
      if (i < 8) checkOutput("t3_sready", sReady, (i == 7) ? 1 : 0);
      applyStimulus();
      if (i == 7) sValid = 1'b0;
    end
    checkOutput("t3_idle_valid", mValid, 0);

    // Reset in mid-frame after word 3 has been taken.
    sValid = 1'b1; sData = makeFrame(16'h0001);
    applyStimulus();
    sValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4_data", mData, 32'(i + 1));
      applyStimulus();
    end
    aresetn = 1'b0;
    applyStimulus();
    aresetn = 1'b1;
    checkOutput("t4_rst_sready", sReady, 1);
    checkOutput("t4_rst_mdata",  mData,  0);
    checkOutput("t4_rst_mlast",  mLast,  0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t4_no_valid", mValid, 0);
      applyStimulus();
    end

    // Frame offered during a stalled drain must wait for the last handshake.
    sValid = 1'b1; sData = makeFrame(16'h0001); mReady = 1'b0;
    applyStimulus();
    sData = makeFrame(16'h0C00);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_stall_sready", sReady, 0);
      checkOutput("t5_stall_data",   mData,  32'h0001);
      applyStimulus();
    end
    mReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t5_data",   mData,  32'(i + 1));
      checkOutput("t5_sready", sReady, (i == 7) ? 1 : 0);
      applyStimulus();
      if (i == 7) sValid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput("t5_c_valid", mValid, 1);
      checkOutput("t5_c_data",  mData,  32'(16'h0C00 + i));
      checkOutput("t5_c_last",  mLast,  (i == 7) ? 1 : 0);
      applyStimulus();
    end
    checkOutput("t5_idle_valid", mValid, 0);

    // Single-word frames: every word is last and frames overlap.
    checkOutput("t6_rst_valid", m1Valid, 0);
    s1Valid = 1'b1; s1Data = 8'hAA; m1Ready = 1'b1;
    applyStimulus();
    checkOutput("t6_aa_valid",  m1Valid, 1);
    checkOutput("t6_aa_data",   m1Data,  32'hAA);
    checkOutput("t6_aa_last",   m1Last,  1);
    checkOutput("t6_aa_sready", s1Ready, 1);
    s1Data = 8'h55;
    applyStimulus();
    s1Valid = 1'b0;
    checkOutput("t6_55_valid", m1Valid, 1);
    checkOutput("t6_55_data",  m1Data,  32'h55);
    checkOutput("t6_55_last",  m1Last,  1);
    applyStimulus();
    checkOutput("t6_idle_valid", m1Valid, 0);
    checkOutput("t6_idle_last",  m1Last,  0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
